// File: rtl/lsu_clkgate_ctl_pkg.sv
// Shared LSU clock-gating types: FSM state encoding, default widths and reset constants.
package lsu_clkgate_ctl_pkg;

  localparam int unsigned HYST_W_DEF  = 4;
  localparam int unsigned RATIO_W_DEF = 3;

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    COUNTDOWN = 2'd1,
    GATED     = 2'd2,
    WAKE      = 2'd3
  } lsu_cg_state_t;

  localparam lsu_cg_state_t CG_STATE_RST      = ACTIVE;
  localparam logic          CG_GATE_ENTRY_RST = 1'b0;

  // No pipe or buffer activity and no new work arriving.
  function automatic logic cg_quiet(input logic busy, input logic wake);
    return ~busy & ~wake;
  endfunction

endpackage

// File: rtl/lsu_busclk_div.sv
// Core-to-bus clock strobe: free-running ratio counter, independent of the gating FSM.
module lsu_busclk_div
  import lsu_clkgate_ctl_pkg::*;
#(
  parameter int unsigned RATIO_W = RATIO_W_DEF
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [RATIO_W-1:0] i_ratio,
  output logic               o_strobe
);

  logic [RATIO_W-1:0] r_bcnt;
  logic               w_hit;

  // >= rather than == so a ratio lowered below the count fires at once and restarts.
  assign w_hit    = (r_bcnt >= i_ratio);
  assign o_strobe = w_hit;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_bcnt <= '0;
    end else if (w_hit) begin
      r_bcnt <= '0;
    end else begin
      r_bcnt <= r_bcnt + RATIO_W'(1);
    end
  end

endmodule

// File: rtl/lsu_clkgate_ctl.sv
// LSU clock-gating controller: idle-hysteresis FSM for the free clock plus the bus clock strobe.
module lsu_clkgate_ctl
  import lsu_clkgate_ctl_pkg::*;
#(
  parameter int unsigned HYST_W  = HYST_W_DEF,
  parameter int unsigned RATIO_W = RATIO_W_DEF
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               clk_override,
  input  logic [RATIO_W-1:0] bus_clk_ratio,
  input  logic [HYST_W-1:0]  idle_hyst,
  input  logic               lsu_busy_any,
  input  logic               wake_req,
  output logic               lsu_free_clken,
  output logic               lsu_bus_clk_en,
  output logic               lsu_wake_stall,
  output logic               lsu_idle,
  output logic               lsu_gate_entry
);

  lsu_cg_state_t     r_state;
  lsu_cg_state_t     w_state_nxt;
  logic [HYST_W-1:0] r_hcnt;
  logic [HYST_W-1:0] w_hcnt_nxt;
  logic              r_gate_entry;
  logic              w_gate_entry_nxt;
  logic              w_quiet;
  logic              w_gated;

  assign w_quiet = cg_quiet(lsu_busy_any, wake_req);
  assign w_gated = (r_state == GATED);

  // Next-state and hysteresis count; override wins over every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    case (r_state)
      ACTIVE: begin
        if (w_quiet) begin
          if (idle_hyst == '0) begin
            w_state_nxt = GATED;
          end else begin
            w_state_nxt = COUNTDOWN;
            w_hcnt_nxt  = idle_hyst;
          end
        end
      end
      COUNTDOWN: begin
        if (!w_quiet) begin
          w_state_nxt = ACTIVE;
        end else if (r_hcnt == HYST_W'(1)) begin
          w_state_nxt = GATED;
        end else begin
          w_hcnt_nxt = r_hcnt - HYST_W'(1);
        end
      end
      GATED: begin
        if (wake_req | lsu_busy_any) begin
          w_state_nxt = WAKE;
        end
      end
      WAKE: begin
        w_state_nxt = ACTIVE;
      end
      default: begin
        w_state_nxt = ACTIVE;
      end
    endcase
    if (clk_override) begin
      w_state_nxt = ACTIVE;
      w_hcnt_nxt  = r_hcnt;
    end
    w_gate_entry_nxt = (w_state_nxt == GATED) && (r_state != GATED);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state      <= CG_STATE_RST;
      r_hcnt       <= '0;
      r_gate_entry <= CG_GATE_ENTRY_RST;
    end else begin
      r_state      <= w_state_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_gate_entry <= w_gate_entry_nxt;
    end
  end

  // Override opens the clock header in the same cycle and suppresses the stall.
  assign lsu_free_clken = ~w_gated | clk_override;
  assign lsu_wake_stall = w_gated & wake_req & ~clk_override;
  assign lsu_idle       = w_gated;
  assign lsu_gate_entry = r_gate_entry;

  lsu_busclk_div #(
    .RATIO_W (RATIO_W)
  ) u_busclk_div (
    .clk      (clk),
    .rst_l    (rst_l),
    .i_ratio  (bus_clk_ratio),
    .o_strobe (lsu_bus_clk_en)
  );

endmodule

// File: tb/tb_lsu_clkgate_ctl.sv
// Scoreboard bench for lsu_clkgate_ctl: directed per-cycle stimulus, expected outputs queued and checked by a monitor.
module tb_lsu_clkgate_ctl;

  localparam int unsigned HYST_W  = 4;
  localparam int unsigned RATIO_W = 3;

  logic               clk = 1'b0;
  logic               rst_l;
  logic               clk_override;
  logic [RATIO_W-1:0] bus_clk_ratio;
  logic [HYST_W-1:0]  idle_hyst;
  logic               lsu_busy_any;
  logic               wake_req;
  logic               lsu_free_clken;
  logic               lsu_bus_clk_en;
  logic               lsu_wake_stall;
  logic               lsu_idle;
  logic               lsu_gate_entry;

  always #5 clk = ~clk;

  lsu_clkgate_ctl #(
    .HYST_W  (HYST_W),
    .RATIO_W (RATIO_W)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .clk_override   (clk_override),
    .bus_clk_ratio  (bus_clk_ratio),
    .idle_hyst      (idle_hyst),
    .lsu_busy_any   (lsu_busy_any),
    .wake_req       (wake_req),
    .lsu_free_clken (lsu_free_clken),
    .lsu_bus_clk_en (lsu_bus_clk_en),
    .lsu_wake_stall (lsu_wake_stall),
    .lsu_idle       (lsu_idle),
    .lsu_gate_entry (lsu_gate_entry)
  );

  typedef struct packed {
    logic clken;
    logic stall;
    logic idle;
    logic entry;
    logic bus;
  } exp_t;

  exp_t               exp_q[$];
  int                 id_q[$];
  int                 n_chk   = 0;
  int                 n_fail  = 0;
  int                 step_id = 0;
  int                 cyc     = 0;
  logic [RATIO_W-1:0] n_ratio = 3'd3;
  logic [HYST_W-1:0]  n_hyst  = 4'd4;

  function automatic void chk(input string nm, input int id, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", nm, id, act, req);
    end
  endfunction

  // One cycle: drive inputs just after the edge and queue the hand-computed outputs.
  // e_bus < 0 means the strobe follows the ratio-3 schedule (cycle index mod 4 == 3).
  task automatic step(input logic r, input logic busy, input logic wake, input logic ovr,
                      input logic e_clken, input logic e_stall, input logic e_idle,
                      input logic e_entry, input int e_bus);
    exp_t e;
    @(posedge clk);
    if (rst_l) cyc++;
    #1;
    rst_l         = r;
    lsu_busy_any  = busy;
    wake_req      = wake;
    clk_override  = ovr;
    bus_clk_ratio = n_ratio;
    idle_hyst     = n_hyst;
    if (!r) cyc = 0;
    e.clken = e_clken;
    e.stall = e_stall;
    e.idle  = e_idle;
    e.entry = e_entry;
    e.bus   = (e_bus < 0) ? (r && ((cyc % 4) == 3)) : (e_bus != 0);
    exp_q.push_back(e);
    id_q.push_back(step_id);
    step_id++;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    int   id;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        chk("free_clken", id, lsu_free_clken, e.clken);
        chk("wake_stall", id, lsu_wake_stall, e.stall);
        chk("idle",       id, lsu_idle,       e.idle);
        chk("gate_entry", id, lsu_gate_entry, e.entry);
        chk("bus_clk_en", id, lsu_bus_clk_en, e.bus);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_l         = 1'b0;
    clk_override  = 1'b0;
    lsu_busy_any  = 1'b0;
    wake_req      = 1'b0;
    bus_clk_ratio = 3'd3;
    idle_hyst     = 4'd4;

    // Reset values, then quiet from cycle 0: gated at cycle 5, strobes at 3, 7, 11 ...
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    quiet(5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);

    // One-cycle wake: stall that cycle, clock on in WAKE, full hysteresis afterwards.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    quiet(5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);

    // Busy wakes without stall; busy at hcnt=2 aborts the countdown, which then restarts in full.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    quiet(4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    quiet(5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);

    // Simultaneous wake and busy in GATED stalls; busy on the hcnt=1 edge wins.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    quiet(5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    quiet(5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);

    // Override in GATED: clock on at once, stall masked, no gating while held.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    quiet(5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);

    // Asynchronous reset while GATED on a would-be strobe cycle.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    // Reset mid-COUNTDOWN, then idle_hyst=0 gates one cycle after the first quiet cycle.
    quiet(3);
    n_hyst = 4'd0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    quiet(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);

    // Ratio: reset value with ratio 0, then 5 lowered to 1 at bcnt=4; strobe continues while gated.
    n_ratio = 3'd0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    n_ratio = 3'd5;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    n_ratio = 3'd1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_clkgate_ctl.md
# lsu_clkgate_ctl

LSU clock-gating controller: decides when the LSU free clock may be shut off and generates the periodic core-to-bus clock enable. Sits beside the LSU clock domain block and drives its free-clock and bus-clock header enables. An idle-hysteresis state machine handles entry into and exit from the gated state. A ratio counter produces the bus strobe.

## Interface
Parameters:
- HYST_W, 4, width of the idle-hysteresis count
- RATIO_W, 3, width of the bus clock ratio field

Ports:
- clk  in  1  core clock; the block's single clock
- rst_l  in  1  reset, asynchronous, active-low
- clk_override  in  1  disables gating; forces the free clock on
- bus_clk_ratio  in  RATIO_W  core:bus ratio minus 1; 0 means 1:1; quasi-static
- idle_hyst  in  HYST_W  number of quiet cycles required before gating; quasi-static
- lsu_busy_any  in  1  OR of pipe valids dc1..dc5 and all buffers non-empty (stbuf, read, write)
- wake_req  in  1  new LSU work: decode-stage packet valid or DMA DCCM request
- lsu_free_clken  out  1  enable for the LSU free clock header
- lsu_bus_clk_en  out  1  one-cycle bus clock strobe
- lsu_wake_stall  out  1  hold decode/DMA this cycle while the clock restarts
- lsu_idle  out  1  status: LSU clock is gated
- lsu_gate_entry  out  1  perf pulse, one cycle, on entry to GATED

## Operation
- Decided: one clock (clk); reset rst_l is asynchronous and active-low.
- FSM states: ACTIVE, COUNTDOWN, GATED, WAKE. Reset state is ACTIVE.
- quiet = ~lsu_busy_any & ~wake_req.
- ACTIVE:
  - quiet with idle_hyst==0 -> GATED.
  - quiet with idle_hyst!=0 -> COUNTDOWN; load hcnt = idle_hyst.
  - otherwise stay in ACTIVE.
- COUNTDOWN:
  - ~quiet -> ACTIVE.
  - quiet with hcnt==1 -> GATED.
  - otherwise hcnt decrements.
  - A change to idle_hyst here is ignored until the next load.
- GATED:
  - wake_req | lsu_busy_any -> WAKE.
  - otherwise stay in GATED.
- WAKE: always -> ACTIVE next cycle. Countdown cannot start from WAKE.
- clk_override=1: next state is forced to ACTIVE from any state; hcnt is not loaded.
- Outputs:
  - lsu_free_clken = (state!=GATED) | clk_override
  - lsu_wake_stall = (state==GATED) & wake_req & ~clk_override
  - lsu_idle = (state==GATED)
  - lsu_gate_entry = 1 in the first cycle state==GATED; registered from the transition
- Bus ratio counter bcnt (RATIO_W bits):
  - If bcnt >= bus_clk_ratio, next bcnt = 0; otherwise bcnt+1.
  - lsu_bus_clk_en = (bcnt >= bus_clk_ratio).
  - If bus_clk_ratio is lowered below bcnt, the strobe fires immediately and the counter restarts at 0.
  - The counter is not affected by the FSM or clk_override. The bus strobe keeps running while gated.

## Timing
- Reset values:
  - state=ACTIVE, hcnt=0, bcnt=0.
  - lsu_free_clken=1, lsu_wake_stall=0, lsu_idle=0, lsu_gate_entry=0.
  - lsu_bus_clk_en=(bus_clk_ratio==0).
- Gating latency: quiet continuously from cycle t gives lsu_free_clken=0 from cycle t+idle_hyst+1 (1 cycle into COUNTDOWN, then idle_hyst-1 decrements). With idle_hyst==0, gating starts at t+1.
- Wake latency:
  - wake_req in GATED at cycle w: lsu_wake_stall=1 at w only; lsu_free_clken=1 from w+1 (WAKE); ACTIVE at w+2.
  - The requester re-presents the request at w+1.
- Simultaneous wake_req and lsu_busy_any in GATED: -> WAKE; stall still asserted.
- Busy at the same edge hcnt reaches 1: busy wins -> ACTIVE.
- Asynchronous reset mid-COUNTDOWN or mid-GATED: immediately ACTIVE, lsu_free_clken=1.
- Bus strobe period is bus_clk_ratio+1 cycles; first strobe after reset is at cycle bus_clk_ratio.

## Structure
- Shared LSU types package: enum lsu_cg_state_t {ACTIVE, COUNTDOWN, GATED, WAKE} and reset constants.
- State, hcnt, bcnt and lsu_gate_entry use flops with asynchronous active-low reset.
- One sub-module: lsu_busclk_div, containing bcnt and the strobe compare. The FSM stays in the top level.

## Test plan
- Reset release, ratio=3, idle_hyst=4, busy=0 -> bus strobe at cycles 3,7,11; lsu_free_clken drops at cycle 5; lsu_gate_entry pulses at cycle 5.
- While GATED, wake_req for 1 cycle -> stall=1 that cycle only; clken=1 next cycle; ACTIVE one cycle later; no gating for the following 5 quiet cycles.
- COUNTDOWN with hcnt=2 and busy asserted -> ACTIVE; after busy drops, the full 4-cycle hysteresis restarts.
- clk_override=1 in GATED -> clken=1 the same cycle; stall=0; state ACTIVE next cycle; no gating while override is held.
- ratio lowered from 5 to 1 at bcnt=4 -> strobe that cycle; then period 2.
- rst_l asserted mid-COUNTDOWN -> outputs return to reset values asynchronously; idle_hyst=0 then gates 1 cycle after the first quiet cycle.
